// File: rtl/led_sequencer.sv
// Prescaled LED pattern engine (binary count, bouncing scanner, breathing, off)
// with a free-running PWM dimmer on the registered LED outputs.
module led_sequencer #(
  parameter int TICK_DIV    = 16777216,
  parameter int PWM_W       = 8,
  parameter int BREATH_STEP = 16
) (
  input  logic             sysclock,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] brightness,
  output logic [7:0]       leds,
  output logic [7:0]       pattern,
  output logic             tick
);

  localparam int               CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       STEP8    = 8'(BREATH_STEP);

  localparam logic [1:0] MODE_BIN    = 2'd0;
  localparam logic [1:0] MODE_SCAN   = 2'd1;
  localparam logic [1:0] MODE_BREATH = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  logic [CNT_W-1:0] prescale_cnt_q, prescale_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [1:0]       active_mode_q, active_mode_d;
  logic [7:0]       count_q, count_d;
  logic [2:0]       scan_pos_q, scan_pos_d;
  logic             scan_dir_q, scan_dir_d;
  logic [7:0]       breath_lvl_q, breath_lvl_d;
  logic             breath_dir_q, breath_dir_d;
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       pattern_q, pattern_d;
  logic             tick_q, tick_d;

  logic             step;
  logic [8:0]       breath_sum;
  logic [PWM_W-1:0] duty;
  logic             pwm_on;
  logic [7:0]       gated;

  // Breathing drives the duty directly; the other modes use the brightness input.
  assign duty   = (active_mode_q == MODE_BREATH) ? PWM_W'(breath_lvl_q) : brightness;
  assign pwm_on = (pwm_cnt_q < duty);

  for (genvar gi = 0; gi < 8; gi++) begin : g_gate
    assign gated[gi] = pattern_q[gi] & pwm_on;
  end

  always_comb begin
    step           = (prescale_cnt_q == CNT_LAST);
    prescale_cnt_d = step ? '0 : prescale_cnt_q + CNT_W'(1);
    pwm_cnt_d      = pwm_cnt_q + PWM_W'(1);
    tick_d         = step;
    active_mode_d  = active_mode_q;
    count_d        = count_q;
    scan_pos_d     = scan_pos_q;
    scan_dir_d     = scan_dir_q;
    breath_lvl_d   = breath_lvl_q;
    breath_dir_d   = breath_dir_q;
    breath_sum     = {1'b0, breath_lvl_q} + {1'b0, STEP8};

    if (step) begin
      active_mode_d = mode;
      // A mode change loads the new mode's initial state instead of stepping.
      if (mode != active_mode_q) begin
        case (mode)
          MODE_BIN: count_d = 8'd0;
          MODE_SCAN: begin
            scan_pos_d = 3'd0;
            scan_dir_d = 1'b0;
          end
          MODE_BREATH: begin
            breath_lvl_d = 8'd0;
            breath_dir_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (active_mode_q)
          MODE_BIN: count_d = count_q + 8'd1;
          MODE_SCAN: begin
            if (!scan_dir_q) begin
              if (scan_pos_q == 3'd7) begin
                scan_pos_d = 3'd6;
                scan_dir_d = 1'b1;
              end else begin
                scan_pos_d = scan_pos_q + 3'd1;
              end
            end else begin
              if (scan_pos_q == 3'd0) begin
                scan_pos_d = 3'd1;
                scan_dir_d = 1'b0;
              end else begin
                scan_pos_d = scan_pos_q - 3'd1;
              end
            end
          end
          MODE_BREATH: begin
            if (!breath_dir_q) begin
              if (breath_sum > 9'd255) begin
                breath_lvl_d = 8'd255;
                breath_dir_d = 1'b1;
              end else begin
                breath_lvl_d = breath_sum[7:0];
              end
            end else begin
              if (breath_lvl_q < STEP8) begin
                breath_lvl_d = 8'd0;
                breath_dir_d = 1'b0;
              end else begin
                breath_lvl_d = breath_lvl_q - STEP8;
              end
            end
          end
          default: ;
        endcase
      end
    end

    case (active_mode_d)
      MODE_BIN:    pattern_d = count_d;
      MODE_SCAN:   pattern_d = 8'b1 << scan_pos_d;
      MODE_BREATH: pattern_d = breath_lvl_d;
      default:     pattern_d = 8'd0;
    endcase

    case (active_mode_q)
      MODE_BIN, MODE_SCAN: leds_d = gated;
      MODE_BREATH:         leds_d = {8{pwm_on}};
      MODE_OFF:            leds_d = 8'd0;
      default:             leds_d = 8'd0;
    endcase
  end

  always_ff @(posedge sysclock) begin
    if (!reset_n) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      active_mode_q  <= MODE_BIN;
      count_q        <= '0;
      scan_pos_q     <= '0;
      scan_dir_q     <= 1'b0;
      breath_lvl_q   <= '0;
      breath_dir_q   <= 1'b0;
      leds_q         <= '0;
      pattern_q      <= '0;
      tick_q         <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      active_mode_q  <= active_mode_d;
      count_q        <= count_d;
      scan_pos_q     <= scan_pos_d;
      scan_dir_q     <= scan_dir_d;
      breath_lvl_q   <= breath_lvl_d;
      breath_dir_q   <= breath_dir_d;
      leds_q         <= leds_d;
      pattern_q      <= pattern_d;
      tick_q         <= tick_d;
    end
  end

  assign leds    = leds_q;
  assign pattern = pattern_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: two instances (TICK_DIV=4 and TICK_DIV=2)
// share the same stimulus; each task checks one feature cycle by cycle.
module tb_led_sequencer;

  logic       sysclock = 1'b0;
  logic       reset_n  = 1'b0;
  logic [1:0] mode     = 2'd0;
  logic [7:0] brightness = 8'd255;
  logic [7:0] leds4, pattern4, leds2, pattern2;
  logic       tick4, tick2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 sysclock = ~sysclock;

  led_sequencer #(.TICK_DIV(4), .PWM_W(8), .BREATH_STEP(16)) u_dut4 (
    .sysclock  (sysclock),
    .reset_n   (reset_n),
    .mode      (mode),
    .brightness(brightness),
    .leds      (leds4),
    .pattern   (pattern4),
    .tick      (tick4)
  );

  led_sequencer #(.TICK_DIV(2), .PWM_W(8), .BREATH_STEP(16)) u_dut2 (
    .sysclock  (sysclock),
    .reset_n   (reset_n),
    .mode      (mode),
    .brightness(brightness),
    .leds      (leds2),
    .pattern   (pattern2),
    .tick      (tick2)
  );

  task automatic step();
    @(posedge sysclock);
    #1;
  endtask

  // After this returns, edge k (k >= 1) is the k-th edge with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Scanner pattern after edge k with TICK_DIV=4 (mode 1 selected from reset).
  function automatic logic [7:0] scan_pat(int k);
    int         m;
    int         pos;
    logic [7:0] one;
    one = 8'd1;
    if (k < 4) return 8'd0;
    m   = ((k / 4) - 1) % 14;
    pos = (m <= 7) ? m : 14 - m;
    return one << pos;
  endfunction

  // Breathing level after edge j with TICK_DIV=2, BREATH_STEP=16.
  function automatic int breath_at(int j);
    int i;
    if (j < 2) return 0;
    i = ((j / 2) - 1) % 32;
    if (i <= 15) return 16 * i;
    if (i == 16) return 255;
    return 255 - 16 * (i - 16);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    mode = 2'd0;
    brightness = 8'd255;
    step(); step(); step();
    tests_run++;
    if ({tick4, pattern4, leds4} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_dut4 got tick=%0b pat=%h leds=%h want 0/00/00", tick4, pattern4, leds4);
    end
    tests_run++;
    if ({tick2, pattern2, leds2} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_dut2 got tick=%0b pat=%h leds=%h want 0/00/00", tick2, pattern2, leds2);
    end
  endtask

  task automatic test_binary();
    logic       exp_tick;
    logic [7:0] exp_pat, exp_leds, prev_pat;
    mode = 2'd0;
    brightness = 8'd255;
    do_reset();
    for (int k = 1; k <= 1032; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      exp_pat  = 8'(k / 4);
      prev_pat = 8'((k - 1) / 4);
      exp_leds = (((k - 1) % 256) != 255) ? prev_pat : 8'd0;
      tests_run++;
      if ({tick4, pattern4, leds4} !== {exp_tick, exp_pat, exp_leds}) begin
        tests_failed++;
        $display("FAIL binary k=%0d got tick=%0b pat=%h leds=%h want tick=%0b pat=%h leds=%h",
                 k, tick4, pattern4, leds4, exp_tick, exp_pat, exp_leds);
      end
    end
  endtask

  task automatic test_scanner();
    logic       exp_tick;
    logic [7:0] exp_pat, exp_leds;
    mode = 2'd1;
    brightness = 8'd255;
    do_reset();
    for (int k = 1; k <= 4 * 32; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      exp_pat  = scan_pat(k);
      exp_leds = scan_pat(k - 1);
      tests_run++;
      if ({tick4, pattern4, leds4} !== {exp_tick, exp_pat, exp_leds}) begin
        tests_failed++;
        $display("FAIL scanner k=%0d got tick=%0b pat=%h leds=%h want tick=%0b pat=%h leds=%h",
                 k, tick4, pattern4, leds4, exp_tick, exp_pat, exp_leds);
      end
    end
  endtask

  task automatic test_breathing();
    logic       exp_tick;
    logic [7:0] exp_pat, exp_leds;
    mode = 2'd2;
    brightness = 8'd0;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      step();
      exp_tick = (k % 2 == 0);
      exp_pat  = 8'(breath_at(k));
      exp_leds = (((k - 1) % 256) < breath_at(k - 1)) ? 8'hFF : 8'h00;
      tests_run++;
      if ({tick2, pattern2, leds2} !== {exp_tick, exp_pat, exp_leds}) begin
        tests_failed++;
        $display("FAIL breathing k=%0d got tick=%0b pat=%h leds=%h want tick=%0b pat=%h leds=%h",
                 k, tick2, pattern2, leds2, exp_tick, exp_pat, exp_leds);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] want [6];
    int         gap  [6];
    want = '{8'h05, 8'h05, 8'h01, 8'h02, 8'h00, 8'h01};
    gap  = '{22, 1, 1, 4, 4, 4};
    mode = 2'd0;
    brightness = 8'd255;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < gap[i]; c++) step();
      tests_run++;
      if (pattern4 !== want[i]) begin
        tests_failed++;
        $display("FAIL mode_switch step=%0d got pat=%h want %h", i, pattern4, want[i]);
      end
      if (i == 0) mode = 2'd1;
      if (i == 3) mode = 2'd0;
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd0;
    brightness = 8'd255;
    do_reset();
    for (int k = 1; k <= 223; k++) step();
    tests_run++;
    if (pattern4 !== 8'h37) begin
      tests_failed++;
      $display("FAIL reset_mid_pre got pat=%h want 37", pattern4);
    end
    reset_n = 1'b0;
    step();
    tests_run++;
    if ({tick4, pattern4, leds4} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_clear got tick=%0b pat=%h leds=%h want 0/00/00", tick4, pattern4, leds4);
    end
    reset_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      tests_run++;
      if ({tick4, pattern4} !== {(j == 4), 8'((j == 4) ? 1 : 0)}) begin
        tests_failed++;
        $display("FAIL reset_mid_restart j=%0d got tick=%0b pat=%h want tick=%0b pat=%0d",
                 j, tick4, pattern4, (j == 4), (j == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_off();
    mode = 2'd3;
    brightness = 8'd255;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      tests_run++;
      if ({tick4, pattern4, leds4} !== {(k % 4 == 0), 16'd0}) begin
        tests_failed++;
        $display("FAIL off k=%0d got tick=%0b pat=%h leds=%h want tick=%0b pat=00 leds=00",
                 k, tick4, pattern4, leds4, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_brightness();
    int on_cnt;
    mode = 2'd0;
    brightness = 8'd0;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step();
      tests_run++;
      if (leds4 !== 8'h00) begin
        tests_failed++;
        $display("FAIL dim_zero k=%0d got leds=%h want 00", k, leds4);
      end
    end
    tests_run++;
    if (pattern4 !== 8'd10) begin
      tests_failed++;
      $display("FAIL dim_zero_pat got pat=%h want 0a", pattern4);
    end
    mode = 2'd1;
    brightness = 8'd128;
    do_reset();
    for (int k = 1; k <= 8; k++) step();
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (leds4 !== 8'h00) on_cnt++;
    end
    tests_run++;
    if (on_cnt !== 128) begin
      tests_failed++;
      $display("FAIL dim_half got on_cycles=%0d want 128", on_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_scanner();
    test_breathing();
    test_mode_switch();
    test_reset_mid();
    test_off();
    test_brightness();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Downstream LED stage for the board's free-running clock domain. Replaces direct counter-bit LED assignment with a prescaled pattern engine and a per-LED PWM dimmer.
- Driven by the differential-buffered system clock. Outputs go straight to PL_LED1..8 (leds[0] = PL_LED1).
- Pattern modes: binary count, bouncing scanner, breathing, off.

Parameters:
- TICK_DIV, 16777216, sysclock cycles per pattern tick; legal range >= 2.
- PWM_W, 8, PWM counter and duty width.
- BREATH_STEP, 16, duty increment per tick in breathing mode; legal range 1..255.

Ports:
- sysclock  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  2  pattern select: 0 binary, 1 scanner, 2 breathing, 3 off.
- brightness  in  PWM_W  PWM duty for modes 0 and 1.
- leds  out  8  LED drive, registered.
- pattern  out  8  current pattern state (debug), registered.
- tick  out  1  one-cycle strobe at each pattern step.

Behaviour:
- Reset is synchronous: reset_n low at a sysclock edge sets every register to 0 on that edge.
  - Affected state: prescale_cnt, pwm_cnt, active_mode (=0), count, scan_pos, scan_dir (=up), breath_lvl, breath_dir (=up), leds, pattern, tick.
  - Reset wins over every simultaneous event. Reset mid-pattern restarts cleanly.
- Prescaler:
  - prescale_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle after prescale_cnt==TICK_DIV-1, so it is registered.
  - Result: one tick per TICK_DIV cycles, with the first tick TICK_DIV cycles after reset release.
- PWM:
  - pwm_cnt is free-running, PWM_W bits, wraps 2^PWM_W-1 -> 0.
  - pwm_on = (pwm_cnt < duty), unsigned compare.
  - duty=0 gives always off. duty=255 gives on 255 of every 256 cycles.
  - brightness is sampled every cycle; no tick alignment.
- Mode handling:
  - mode is captured into active_mode only on a tick.
  - If mode != active_mode at a tick, the engine loads the new mode's initial state instead of advancing.
  - Initial states: count=0; scan_pos=0, dir=up; breath_lvl=0, dir=up.
  - A mode change between ticks has no effect until the next tick.
- Mode 0 (binary):
  - pattern = count. count increments by 1 per tick and wraps 0xFF -> 0x00.
- Mode 1 (scanner):
  - pattern = one-hot (1 << scan_pos).
  - Up direction: pos+1 per tick; at pos 7 the direction flips and the next value is 6.
  - Down direction: pos-1 per tick; at pos 0 the direction flips and the next value is 1.
  - Period is 14 ticks: 0,1..7,6..1,0,...
- Mode 2 (breathing):
  - pattern = breath_lvl[7:0]; duty = breath_lvl.
  - Up: if breath_lvl+BREATH_STEP > 255, clamp to 255 and set dir=down; otherwise add BREATH_STEP.
  - Down: if breath_lvl < BREATH_STEP, clamp to 0 and set dir=up; otherwise subtract BREATH_STEP.
  - Use a 9-bit intermediate for the sum; no wrap permitted.
- Mode 3 (off):
  - pattern = 0, leds = 0. Prescaler and PWM keep running.
- Output stage (registered, 1-cycle latency from pattern/pwm_cnt/brightness):
  - modes 0/1: leds <= pattern & {8{pwm_on}}.
  - mode 2: leds <= {8{pwm_on}}.
  - mode 3: leds <= 0.
- A tick in the same cycle as prescale_cnt wrap and pwm_cnt wrap is handled independently; there is no interaction.

Test Plan:
- TICK_DIV=4, mode=0, brightness=255, release reset -> tick pulses at cycles 4,8,12...; pattern 0,1,2,3...; leds equal pattern except in the pwm_cnt==255 cycle (0x00). After 256 ticks pattern wraps to 0x00.
- TICK_DIV=4, mode=1 -> pattern sequence 0x01,0x02,..0x80,0x40,..0x01,0x02 over ticks. No repeat of 0x80 or 0x01 at the turnarounds.
- TICK_DIV=2, mode=2, BREATH_STEP=16 -> breath_lvl 0,16,..,240,255,239,..,15,0,16. Over 256 cycles, leds count of 0xFF cycles equals the current breath_lvl.
- Mode 0 running at count=5, set mode=1 mid-interval -> pattern stays 5 until the next tick, then becomes 0x01 (initial state, no advance). Switching back to 0 gives pattern 0x00.
- brightness=0 in mode 0 -> leds=0x00 always. brightness=128 -> leds non-zero for exactly 128 of every 256 cycles.
- Assert reset_n=0 for 1 cycle at count=0x37 -> next cycle all outputs 0. After release, pattern restarts at 0 and first tick comes TICK_DIV cycles later.
